// File: rtl/adc_fifo_pkg.sv
// adc_fifo_pkg
// Shared definitions for the ADC sample FIFO: register byte offsets,
// CTRL/STATUS field positions, the FIFO entry layout and a helper that
// formats an entry as a DATA register word.
package adc_fifo_pkg;

    localparam int NUM_CH   = 4;
    localparam int CH_ID_W  = 2;
    localparam int SAMPLE_W = 16;
    localparam int ENTRY_W  = CH_ID_W + SAMPLE_W;

    // Register byte offsets (decode compares wb_addr[7:2] with bits [1:0] zeroed)
    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_THRESH = 8'h08;
    localparam logic [7:0] REG_DATA   = 8'h0C;

    // CTRL fields
    localparam int CTRL_MASK_LSB = 0;
    localparam int CTRL_IRQ_EN   = 4;
    localparam int CTRL_FLUSH    = 8;

    // STATUS fields (level occupies the low bits)
    localparam int STAT_EMPTY    = 16;
    localparam int STAT_FULL     = 17;
    localparam int STAT_OVERFLOW = 18;
    localparam int STAT_DROP     = 19;

    typedef struct packed {
        logic [CH_ID_W-1:0]  id;
        logic [SAMPLE_W-1:0] sample;
    } entry_t;

    // DATA word for a valid entry: {valid, 13'b0, id, sample}
    function automatic logic [31:0] data_word(entry_t e);
        return {1'b1, 13'b0, e};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with show-ahead output: dout always presents the oldest
// entry while the FIFO is not empty. Flush empties it and overrides any
// push or pop in the same cycle. A push into a full FIFO is accepted only
// if a pop frees a slot in the same cycle; otherwise it is discarded.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   push, din     write request and data
//   pop           read request (ignored when empty)
//   flush         discard all entries
//   dout          oldest entry (valid when !empty)
//   level         number of stored entries, 0..DEPTH
//   full, empty   level == DEPTH / level == 0
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;
    assign dout    = mem[rd_ptr];

    // Storage array carries no reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo
// Collects 16-bit results from the 4-channel ADC, serialises simultaneous
// strobes (lowest channel first) into {id, sample} entries, buffers them in
// a FIFO and exposes CTRL/STATUS/THRESH/DATA registers on a Wishbone slave.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   ch_data, ch_valid  packed channel results and 1-cycle strobes
//   wb_*               Wishbone slave (wb_sel ignored, full-word accesses)
//   irq                registered level interrupt (level >= thresh)
module adc_sample_fifo
    import adc_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int LVL_W      = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [63:0]           ch_data,
    input  logic [3:0]            ch_valid,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    input  logic                  wb_we,
    input  logic [3:0]            wb_sel,
    input  logic                  wb_stb,
    output logic                  wb_ack,
    output logic                  irq
);

    logic [NUM_CH-1:0]   ch_mask;
    logic                irq_en;
    logic [LVL_W-1:0]    thresh;
    logic                overflow;
    logic                drop;
    logic [NUM_CH-1:0]   pend;
    logic [SAMPLE_W-1:0] hold [NUM_CH];

    logic [7:0]          reg_off;
    logic                access;
    logic                rd_acc;
    logic                wr_acc;
    logic                flush;
    logic                pop_req;
    logic                push_req;
    logic [NUM_CH-1:0]   strobe;
    logic [NUM_CH-1:0]   svc_sel;
    logic [CH_ID_W-1:0]  svc_id;
    entry_t              push_entry;
    entry_t              fifo_dout;
    logic [LVL_W-1:0]    fifo_level;
    logic                fifo_full;
    logic                fifo_empty;
    logic                overflow_evt;
    logic                drop_evt;
    logic [31:0]         rdata;
    logic                unused_bus_bits;

    // Byte selects, the low address bits and most write-data bits carry no
    // meaning here; folding them keeps them visibly consumed
    assign unused_bus_bits = ^{wb_sel, wb_addr, wb_dat_i};

    assign reg_off  = {wb_addr[7:2], 2'b00};
    assign access   = wb_stb && !wb_ack;
    assign rd_acc   = access && !wb_we;
    assign wr_acc   = access && wb_we;
    assign flush    = wr_acc && (reg_off == REG_CTRL) && wb_dat_i[CTRL_FLUSH];
    assign pop_req  = rd_acc && (reg_off == REG_DATA) && !fifo_empty;
    assign strobe   = ch_valid & ch_mask;
    assign push_req = |pend;

    // Lowest-index pending channel wins the single push slot each cycle
    always_comb begin
        svc_sel = '0;
        svc_id  = '0;
        for (int n = NUM_CH - 1; n >= 0; n--) begin
            if (pend[n]) begin
                svc_sel    = '0;
                svc_sel[n] = 1'b1;
                svc_id     = CH_ID_W'(n);
            end
        end
    end

    assign push_entry   = '{id: svc_id, sample: hold[svc_id]};
    assign overflow_evt = push_req && fifo_full && !pop_req && !flush;
    assign drop_evt     = (|(strobe & pend & ~svc_sel)) && !flush;

    // A new strobe always lands in hold; a channel being serviced while it
    // strobes keeps pend set with the fresh value instead of clearing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                hold[n] <= '0;
            end
        end else if (flush) begin
            pend <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                hold[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (strobe[n]) begin
                    hold[n] <= ch_data[SAMPLE_W*n +: SAMPLE_W];
                    pend[n] <= 1'b1;
                end else if (svc_sel[n]) begin
                    pend[n] <= 1'b0;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (pop_req),
        .flush (flush),
        .din   (push_entry),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Configuration and sticky flags; a new flag event wins over a W1C
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_mask  <= '0;
            irq_en   <= 1'b0;
            thresh   <= LVL_W'(1);
            overflow <= 1'b0;
            drop     <= 1'b0;
        end else begin
            if (wr_acc && (reg_off == REG_CTRL)) begin
                ch_mask <= wb_dat_i[CTRL_MASK_LSB +: NUM_CH];
                irq_en  <= wb_dat_i[CTRL_IRQ_EN];
            end
            if (wr_acc && (reg_off == REG_THRESH)) begin
                thresh <= (wb_dat_i[LVL_W-1:0] == '0) ? LVL_W'(1) : wb_dat_i[LVL_W-1:0];
            end
            if (overflow_evt) begin
                overflow <= 1'b1;
            end else if (wr_acc && (reg_off == REG_STATUS) && wb_dat_i[STAT_OVERFLOW]) begin
                overflow <= 1'b0;
            end
            if (drop_evt) begin
                drop <= 1'b1;
            end else if (wr_acc && (reg_off == REG_STATUS) && wb_dat_i[STAT_DROP]) begin
                drop <= 1'b0;
            end
        end
    end

    // Read mux; DATA uses the show-ahead head, popped on the same edge
    always_comb begin
        rdata = '0;
        case (reg_off)
            REG_CTRL: begin
                rdata[CTRL_MASK_LSB +: NUM_CH] = ch_mask;
                rdata[CTRL_IRQ_EN]             = irq_en;
            end
            REG_STATUS: begin
                rdata[LVL_W-1:0]     = fifo_level;
                rdata[STAT_EMPTY]    = fifo_empty;
                rdata[STAT_FULL]     = fifo_full;
                rdata[STAT_OVERFLOW] = overflow;
                rdata[STAT_DROP]     = drop;
            end
            REG_THRESH: begin
                rdata[LVL_W-1:0] = thresh;
            end
            REG_DATA: begin
                if (!fifo_empty) begin
                    rdata = data_word(fifo_dout);
                end
            end
            default: begin
                rdata = '0;
            end
        endcase
    end

    // Bus response and interrupt are both registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack   <= 1'b0;
            wb_dat_o <= '0;
            irq      <= 1'b0;
        end else begin
            wb_ack <= access;
            if (rd_acc) begin
                wb_dat_o <= rdata;
            end
            irq <= irq_en && (fifo_level >= thresh);
        end
    end

endmodule

// File: tb/tb_adc_sample_fifo.sv
// tb_adc_sample_fifo
// Directed bench for adc_sample_fifo: a table of register accesses and
// channel strobes with hand-computed read values, followed by hand-written
// sequences for drop, overflow, interrupt timing, flush and async reset.
module tb_adc_sample_fifo;

    localparam int K_WR  = 0;
    localparam int K_RD  = 1;
    localparam int K_STB = 2;

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h04;
    localparam logic [7:0] A_THRESH = 8'h08;
    localparam logic [7:0] A_DATA   = 8'h0C;

    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  valid;
        logic [63:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] ch_data;
    logic [3:0]  ch_valid;
    logic [7:0]  wb_addr;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic        wb_stb;
    logic        wb_ack;
    logic        irq;

    int   total;
    int   bad;
    vec_t vecs[$];

    adc_sample_fifo #(
        .ADDR_WIDTH (8),
        .DEPTH      (64),
        .LVL_W      (7)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch_data  (ch_data),
        .ch_valid (ch_valid),
        .wb_addr  (wb_addr),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_we    (wb_we),
        .wb_sel   (wb_sel),
        .wb_stb   (wb_stb),
        .wb_ack   (wb_ack),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a sequence stalls
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic void addVec(input int kind, input logic [7:0] addr, input logic [31:0] wdata,
                                   input logic [3:0] valid, input logic [63:0] data,
                                   input logic [31:0] exp, input string name);
        vec_t v;
        v.kind  = kind;
        v.addr  = addr;
        v.wdata = wdata;
        v.valid = valid;
        v.data  = data;
        v.exp   = exp;
        v.name  = name;
        vecs.push_back(v);
    endfunction

    // Bus tasks: drive on the falling edge, sample the ack/data there too
    task automatic wbWrite(input logic [7:0] addr, input logic [31:0] data);
        int waited;
        @(negedge clk);
        wb_addr  = addr;
        wb_dat_i = data;
        wb_we    = 1'b1;
        wb_stb   = 1'b1;
        waited   = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!wb_ack && waited < 8);
        checkOutput("wr_ack", {31'b0, wb_ack}, 32'd1);
        wb_stb = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic wbRead(input logic [7:0] addr, output logic [31:0] data);
        int waited;
        @(negedge clk);
        wb_addr = addr;
        wb_we   = 1'b0;
        wb_stb  = 1'b1;
        waited  = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!wb_ack && waited < 8);
        checkOutput("rd_ack", {31'b0, wb_ack}, 32'd1);
        data   = wb_dat_o;
        wb_stb = 1'b0;
    endtask

    task automatic strobeChannels(input logic [3:0] valid, input logic [63:0] data);
        @(negedge clk);
        ch_valid = valid;
        ch_data  = data;
        @(negedge clk);
        ch_valid = 4'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic readCheck(input logic [7:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] rd;
        wbRead(addr, rd);
        checkOutput(name, rd, exp);
    endtask

    task automatic applyStimulus(input vec_t v);
        case (v.kind)
            K_WR:    wbWrite(v.addr, v.wdata);
            K_RD:    readCheck(v.addr, v.exp, v.name);
            default: strobeChannels(v.valid, v.data);
        endcase
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        ch_data  = '0;
        ch_valid = '0;
        wb_addr  = '0;
        wb_dat_i = '0;
        wb_we    = 1'b0;
        wb_sel   = 4'hF;
        wb_stb   = 1'b0;

        // Register/strobe table with hand-computed read values
        addVec(K_RD,  A_STATUS, 0, 0, 0, 32'h0001_0000, "rst_status");
        addVec(K_RD,  A_THRESH, 0, 0, 0, 32'h0000_0001, "rst_thresh");
        addVec(K_RD,  A_CTRL,   0, 0, 0, 32'h0000_0000, "rst_ctrl");
        addVec(K_WR,  8'h10, 32'hFFFF_FFFF, 0, 0, 0, "");
        addVec(K_RD,  8'h10,    0, 0, 0, 32'h0000_0000, "unmapped_rd");
        addVec(K_RD,  A_CTRL,   0, 0, 0, 32'h0000_0000, "ctrl_after_unmapped");
        addVec(K_WR,  A_THRESH, 32'h0, 0, 0, 0, "");
        addVec(K_RD,  A_THRESH, 0, 0, 0, 32'h0000_0001, "thresh_zero");
        addVec(K_WR,  A_THRESH, 32'h45, 0, 0, 0, "");
        addVec(K_RD,  A_THRESH, 0, 0, 0, 32'h0000_0045, "thresh_rw");
        addVec(K_WR,  A_CTRL,   32'h0F, 0, 0, 0, "");
        addVec(K_RD,  A_CTRL,   0, 0, 0, 32'h0000_000F, "ctrl_rw");
        addVec(K_STB, 0, 0, 4'b0100, 64'h0000_1234_0000_0000, 0, "");
        addVec(K_RD,  A_STATUS, 0, 0, 0, 32'h0000_0001, "lvl_one");
        addVec(K_RD,  A_DATA,   0, 0, 0, 32'h8002_1234, "data_ch2");
        addVec(K_RD,  A_DATA,   0, 0, 0, 32'h0000_0000, "data_empty");
        addVec(K_RD,  A_STATUS, 0, 0, 0, 32'h0001_0000, "lvl_zero");
        addVec(K_STB, 0, 0, 4'b1111, 64'h000D_000C_000B_000A, 0, "");
        addVec(K_RD,  A_DATA,   0, 0, 0, 32'h8000_000A, "burst_ch0");
        addVec(K_RD,  A_DATA,   0, 0, 0, 32'h8001_000B, "burst_ch1");
        addVec(K_RD,  A_DATA,   0, 0, 0, 32'h8002_000C, "burst_ch2");
        addVec(K_RD,  A_DATA,   0, 0, 0, 32'h8003_000D, "burst_ch3");
        addVec(K_RD,  A_STATUS, 0, 0, 0, 32'h0001_0000, "burst_nodrop");
        addVec(K_WR,  A_CTRL,   32'h0B, 0, 0, 0, "");
        addVec(K_STB, 0, 0, 4'b0100, 64'h0000_5555_0000_0000, 0, "");
        addVec(K_RD,  A_STATUS, 0, 0, 0, 32'h0001_0000, "masked_ch2");
        addVec(K_WR,  A_CTRL,   32'h0F, 0, 0, 0, "");

        // Reset values on the outputs while rst_n is held low
        #1;
        checkOutput("rst_dat_o", wb_dat_o, 32'h0);
        checkOutput("rst_ack", {31'b0, wb_ack}, 32'h0);
        checkOutput("rst_irq", {31'b0, irq}, 32'h0);
        idleCycles(2);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // ch1 strobes on two consecutive cycles while ch0 also strobes:
        // ch0 is serviced each time (no drop), ch1's first value is lost
        @(negedge clk);
        ch_valid = 4'b0011;
        ch_data  = 64'h0000_0000_1111_0100;
        @(negedge clk);
        ch_data  = 64'h0000_0000_2222_0200;
        @(negedge clk);
        ch_valid = 4'b0000;
        readCheck(A_DATA,   32'h8000_0100, "drop_ch0_a");
        readCheck(A_DATA,   32'h8000_0200, "drop_ch0_b");
        readCheck(A_DATA,   32'h8001_2222, "drop_ch1_second");
        readCheck(A_STATUS, 32'h0009_0000, "drop_set");
        wbWrite(A_STATUS, 32'h0008_0000);
        readCheck(A_STATUS, 32'h0001_0000, "drop_w1c");

        // 66 samples with no reads: last two overflow
        for (int i = 0; i < 66; i++) begin
            logic [15:0] s;
            s = 16'h0100 + 16'(i);
            strobeChannels(4'b0001 << (i % 4), {4{s}});
        end
        readCheck(A_STATUS, 32'h0006_0040, "ovf_full");
        for (int i = 0; i < 64; i++) begin
            logic [31:0] e;
            e = {1'b1, 13'b0, 2'(i % 4), 16'h0100 + 16'(i)};
            readCheck(A_DATA, e, "ovf_readback");
        end
        readCheck(A_STATUS, 32'h0005_0000, "ovf_drained");
        wbWrite(A_STATUS, 32'h0004_0000);
        readCheck(A_STATUS, 32'h0001_0000, "ovf_w1c");

        // Interrupt threshold timing
        wbWrite(A_THRESH, 32'd8);
        wbWrite(A_CTRL, 32'h1F);
        for (int i = 0; i < 7; i++) begin
            strobeChannels(4'b0001 << (i % 4), {4{16'h0A00 + 16'(i)}});
        end
        idleCycles(2);
        checkOutput("irq_below", {31'b0, irq}, 32'h0);
        strobeChannels(4'b1000, {4{16'h0A07}});
        @(negedge clk);
        checkOutput("irq_push_cycle", {31'b0, irq}, 32'h0);
        @(negedge clk);
        checkOutput("irq_rise", {31'b0, irq}, 32'h1);
        readCheck(A_DATA, 32'h8000_0A00, "irq_pop_data");
        checkOutput("irq_hold_pop", {31'b0, irq}, 32'h1);
        @(negedge clk);
        checkOutput("irq_fall", {31'b0, irq}, 32'h0);

        // Flush keeps flags and config
        wbWrite(A_CTRL, 32'h10F);
        readCheck(A_STATUS, 32'h0001_0000, "flush_a");
        for (int i = 0; i < 5; i++) begin
            strobeChannels(4'b0001 << (i % 4), {4{16'h0B00 + 16'(i)}});
        end
        readCheck(A_STATUS, 32'h0000_0005, "fill_five");
        wbWrite(A_CTRL, 32'h10F);
        readCheck(A_STATUS, 32'h0001_0000, "flush_b");
        readCheck(A_CTRL,   32'h0000_000F, "flush_mask_kept");
        readCheck(A_THRESH, 32'h0000_0008, "flush_thresh_kept");
        readCheck(A_DATA,   32'h0000_0000, "flush_data_empty");

        // Async reset in the middle of a burst
        wbWrite(A_THRESH, 32'd2);
        wbWrite(A_CTRL, 32'h1F);
        strobeChannels(4'b1111, 64'h0004_0003_0002_0001);
        idleCycles(4);
        readCheck(A_STATUS, 32'h0000_0004, "pre_rst_level");
        checkOutput("pre_rst_irq", {31'b0, irq}, 32'h1);
        @(negedge clk);
        ch_valid = 4'b1111;
        ch_data  = 64'h0008_0007_0006_0005;
        @(negedge clk);
        ch_valid = 4'b0000;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_dat_o", wb_dat_o, 32'h0);
        checkOutput("mid_rst_ack", {31'b0, wb_ack}, 32'h0);
        checkOutput("mid_rst_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(3);
        readCheck(A_STATUS, 32'h0001_0000, "post_rst_status");
        readCheck(A_THRESH, 32'h0000_0001, "post_rst_thresh");
        readCheck(A_CTRL,   32'h0000_0000, "post_rst_ctrl");
        readCheck(A_DATA,   32'h0000_0000, "post_rst_data");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_sample_fifo.md
Name: adc_sample_fifo

Overview:
- Downstream consumer of the 4-channel sigma-delta ADC. It takes each channel's 16-bit result and 1-cycle valid strobe and serialises simultaneous strobes into tagged entries.
- Entries are buffered in a synchronous FIFO, so the CPU can drain bursts over Wishbone without losing samples between polls.
- Provides a level-threshold interrupt plus sticky overflow and drop flags. The block sits at its own Wishbone slot next to the ADC peripheral.

Parameters:
- ADDR_WIDTH, 8, Wishbone address width; register decode uses wb_addr[7:2].
- DEPTH, 64, FIFO entries; must be a power of two, at least 4.
- LVL_W, 7, level counter width; equals log2(DEPTH)+1.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- ch_data  in  64  packed channel results; ch n occupies [16n+15:16n].
- ch_valid  in  4  per-channel 1-cycle result strobes.
- wb_addr  in  ADDR_WIDTH  register address.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, registered.
- wb_we  in  1  write enable.
- wb_sel  in  4  byte selects; ignored, all accesses are full-word.
- wb_stb  in  1  strobe.
- wb_ack  out  1  acknowledge.
- irq  out  1  level interrupt.

Behaviour:
- Reset, async via rst_n: wb_dat_o=0, wb_ack=0, irq=0, FIFO empty, pending=0, ch_mask=0, irq_en=0, thresh=1, overflow=0, drop=0.
- Register map:
  - 0x00 CTRL (RW): [3:0] ch_mask; [4] irq_en; [8] flush (write-1, self-clearing, reads 0).
  - 0x04 STATUS: [LVL_W-1:0] level; [16] empty; [17] full; [18] overflow; [19] drop. Writing 1 to bit 18 or 19 clears that flag.
  - 0x08 THRESH (RW): [LVL_W-1:0]; a written value of 0 is stored as 1.
  - 0x0C DATA (RO, pops): [31] valid, [17:16] channel id, [15:0] sample.
  - Other offsets read 0; writes to them are ignored.
- Bus handshake: wb_ack <= wb_stb && !wb_ack, so ack arrives 1 cycle after stb and one access completes every 2 cycles. Side effects (pop, clear, flush) happen once, on the cycle stb is high and ack is low.
- Capture:
  - On ch_valid[n] && ch_mask[n], latch ch_data[n] into hold[n] and set pend[n].
  - If pend[n] is already set and is not being serviced that cycle, overwrite hold[n] and set drop.
  - Masked channels are ignored entirely.
- Arbitration:
  - Each cycle, the lowest-index set pend[n] pushes {n, hold[n]} and its pend clears.
  - If the same channel strobes in the same cycle it is serviced, pend stays set with the new data; this is not a drop.
  - Latency: strobe at edge t -> pend at t -> push at t+1 -> level visible in STATUS read issued from t+2.
  - 4 simultaneous strobes push ch0..ch3 on 4 consecutive cycles.
- FIFO:
  - A push is accepted if level<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the entry is discarded, overflow is set, and the pend still clears.
  - Simultaneous push and pop leaves level unchanged. Pointers wrap modulo DEPTH.
- DATA read:
  - Not empty: return {1'b1, 13'b0, id, sample} and pop.
  - Empty: return 0 and do not pop.
- Flush clears the FIFO, pend and hold; flags and config are kept. Flush takes priority over any push or pop in that cycle.
- irq is registered: irq <= irq_en && (level >= thresh). It deasserts the cycle after level drops below thresh.
- Reset mid-operation: all state returns to reset values immediately; partially assembled pend entries are lost.

Decomposition:
- Shared package adc_fifo_pkg holds:
  - register offsets REG_CTRL/STATUS/THRESH/DATA;
  - bit positions for CTRL and STATUS fields;
  - entry width constant ENTRY_W=18 and the channel-id width.
- One sub-module, sync_fifo:
  - parameterised WIDTH/DEPTH, with push/pop/flush, dout, level, full and empty;
  - show-ahead output, so dout is valid whenever the FIFO is not empty.
- Capture, arbitration and Wishbone logic stay in adc_sample_fifo.

Test Plan:
- Mask=0xF; strobe ch2 with 0x1234 -> STATUS level=1 two cycles later; DATA read = 0x80021234; next DATA read = 0x00000000 and level stays 0.
- Strobe all four channels in one cycle with 0x000A/0x000B/0x000C/0x000D -> four DATA reads return ids 0,1,2,3 in order with those samples; drop=0.
- Strobe ch1 twice, 1 cycle apart, while ch0 strobes in both cycles -> drop=1; ch1 entry holds the second value; W1C of 0x80000 to STATUS clears drop.
- DEPTH=64, fill with 66 samples and no reads -> full=1, level=64, overflow=1; first 64 entries read back intact.
- THRESH=8, irq_en=1 -> irq rises on the cycle after the 8th push; one DATA pop -> irq low on the next cycle.
- Fill 5 entries, write CTRL with flush=1 -> level=0, empty=1, ch_mask preserved. Asserting rst_n=0 mid-burst -> all outputs 0 and thresh reads back 1.
